// File: rtl/tri_pkg.sv
// Shared types for the triangle rasteriser: packed triangle word, coordinate
// widths, FSM states and the edge-function helper used by setup and scan.
package tri_pkg;

   localparam int CW = 9;   // centre-relative input coordinate
   localparam int SW = 11;  // screen coordinate
   localparam int KW = 12;  // edge step coefficient
   localparam int EW = 24;  // edge function value

   typedef logic signed [CW-1:0] coord_t;
   typedef logic signed [SW-1:0] scoord_t;
   typedef logic signed [KW-1:0] coef_t;
   typedef logic signed [EW-1:0] edge_t;

   typedef struct packed {
      coord_t     x1;
      coord_t     y1;
      coord_t     x2;
      coord_t     y2;
      coord_t     x3;
      coord_t     y3;
      logic [9:0] color;
   } tri2d_t;

   typedef enum logic [1:0] {IDLE, SETUP0, SETUP1, SCAN} state_t;

   // E(p) = (px-xa)*(yb-ya) - (py-ya)*(xb-xa), all terms widened first.
   function automatic edge_t edge_value(input scoord_t px, input scoord_t py,
                                        input scoord_t xa, input scoord_t ya,
                                        input scoord_t xb, input scoord_t yb);
      edge_t dx, dy, ex, ey;
      dx = edge_t'(px) - edge_t'(xa);
      dy = edge_t'(py) - edge_t'(ya);
      ex = edge_t'(yb) - edge_t'(ya);
      ey = edge_t'(xb) - edge_t'(xa);
      return dx * ex - dy * ey;
   endfunction

   function automatic scoord_t min3(input scoord_t a, input scoord_t b, input scoord_t c);
      scoord_t m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic scoord_t max3(input scoord_t a, input scoord_t b, input scoord_t c);
      scoord_t m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic scoord_t clamp(input scoord_t v, input scoord_t hi);
      if (v < 0) return '0;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/edge_eval.sv
// One incremental edge function: loads step coefficients and the value at the
// box origin in SETUP1, then steps along x or back to the next row start.
module edge_eval
   import tri_pkg::*;
(
   input  logic    clk,
   input  logic    load,
   input  logic    step_x,
   input  logic    step_row,
   input  scoord_t xa,
   input  scoord_t ya,
   input  scoord_t xb,
   input  scoord_t yb,
   input  scoord_t xmin,
   input  scoord_t ymin,
   output edge_t   e
);

   coef_t coef_a;
   coef_t coef_b;
   edge_t row_e;

   // NOTE: pure datapath registers are not reset; the FSM never reads them
   // before a load, and leaving them out keeps the reset net small.
   always_ff @(posedge clk) begin
      if (load) begin
         coef_a <= coef_t'(ya) - coef_t'(yb);
         coef_b <= coef_t'(xb) - coef_t'(xa);
         e      <= edge_value(xmin, ymin, xa, ya, xb, yb);
         row_e  <= edge_value(xmin, ymin, xa, ya, xb, yb);
      end else if (step_x) begin
         e <= e - edge_t'(coef_a);
      end else if (step_row) begin
         e     <= row_e - edge_t'(coef_b);
         row_e <= row_e - edge_t'(coef_b);
      end
   end

endmodule

// File: rtl/tri_raster.sv
// Fills projected 2D triangles into the frame buffer: two setup cycles, then a
// row-major scan of the clamped bounding box at one position per cycle.
module tri_raster
   import tri_pkg::*;
#(
   parameter int H_RES = 320,
   parameter int V_RES = 240,
   parameter int ADDRW = $clog2(H_RES * V_RES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [63:0]      tri_in,
   output logic             ready_out,
   output logic             pixel_valid,
   output logic [ADDRW-1:0] pixel_addr,
   output logic [9:0]       pixel_color,
   output logic             done
);

   state_t  state, state_n;
   tri2d_t  tri_q;
   scoord_t ax, ay, bx, by, cx, cy;
   scoord_t xmin, xmax, ymin, ymax, x_pos, y_pos;
   scoord_t sx1, sy1, sx2, sy2, sx3, sy3;
   scoord_t xmin_raw, xmax_raw, ymin_raw, ymax_raw;
   logic    box_empty, area_pos;
   edge_t   area, e_ab, e_bc, e_ca;
   logic    accept, load, step_x, step_row, finish, covered;
   logic [ADDRW-1:0] addr, row_addr, base_addr;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n   = state;
      ready_out = 1'b0;
      accept    = 1'b0;
      load      = 1'b0;
      step_x    = 1'b0;
      step_row  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            ready_out = !rst;
            if (valid_in && !rst) begin
               accept  = 1'b1;
               state_n = SETUP0;
            end
         end
         SETUP0: state_n = SETUP1;
         SETUP1: begin
            load = 1'b1;
            if (box_empty || area == '0) begin
               finish  = 1'b1;
               state_n = IDLE;
            end else begin
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (x_pos == xmax) begin
               if (y_pos == ymax) begin
                  finish  = 1'b1;
                  state_n = IDLE;
               end else begin
                  step_row = 1'b1;
               end
            end else begin
               step_x = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      sx1 = scoord_t'(tri_q.x1) + scoord_t'(H_RES / 2);
      sy1 = scoord_t'(tri_q.y1) + scoord_t'(V_RES / 2);
      sx2 = scoord_t'(tri_q.x2) + scoord_t'(H_RES / 2);
      sy2 = scoord_t'(tri_q.y2) + scoord_t'(V_RES / 2);
      sx3 = scoord_t'(tri_q.x3) + scoord_t'(H_RES / 2);
      sy3 = scoord_t'(tri_q.y3) + scoord_t'(V_RES / 2);
      xmin_raw = min3(sx1, sx2, sx3);
      xmax_raw = max3(sx1, sx2, sx3);
      ymin_raw = min3(sy1, sy2, sy3);
      ymax_raw = max3(sy1, sy2, sy3);
   end

   assign area      = edge_value(cx, cy, ax, ay, bx, by);
   assign base_addr = ADDRW'($unsigned(ymin)) * ADDRW'(H_RES) + ADDRW'($unsigned(xmin));

   always_ff @(posedge clk) begin
      if (accept) tri_q <= tri_in;
      if (state == SETUP0) begin
         ax   <= sx1;
         ay   <= sy1;
         bx   <= sx2;
         by   <= sy2;
         cx   <= sx3;
         cy   <= sy3;
         xmin <= clamp(xmin_raw, scoord_t'(H_RES - 1));
         xmax <= clamp(xmax_raw, scoord_t'(H_RES - 1));
         ymin <= clamp(ymin_raw, scoord_t'(V_RES - 1));
         ymax <= clamp(ymax_raw, scoord_t'(V_RES - 1));
         box_empty <= (xmax_raw < 0) || (ymax_raw < 0) ||
                      (xmin_raw >= scoord_t'(H_RES)) || (ymin_raw >= scoord_t'(V_RES)) ||
                      (clamp(xmin_raw, scoord_t'(H_RES - 1)) > clamp(xmax_raw, scoord_t'(H_RES - 1)));
      end
      if (load) begin
         area_pos <= (area > 0);
         x_pos    <= xmin;
         y_pos    <= ymin;
         addr     <= base_addr;
         row_addr <= base_addr;
      end else if (step_x) begin
         x_pos <= x_pos + scoord_t'(1);
         addr  <= addr + ADDRW'(1);
      end else if (step_row) begin
         x_pos    <= xmin;
         y_pos    <= y_pos + scoord_t'(1);
         row_addr <= row_addr + ADDRW'(H_RES);
         addr     <= row_addr + ADDRW'(H_RES);
      end
   end

   edge_eval u_ab (.clk, .load, .step_x, .step_row, .xa(ax), .ya(ay), .xb(bx), .yb(by),
                   .xmin, .ymin, .e(e_ab));
   edge_eval u_bc (.clk, .load, .step_x, .step_row, .xa(bx), .ya(by), .xb(cx), .yb(cy),
                   .xmin, .ymin, .e(e_bc));
   edge_eval u_ca (.clk, .load, .step_x, .step_row, .xa(cx), .ya(cy), .xb(ax), .yb(ay),
                   .xmin, .ymin, .e(e_ca));

   // Inclusive edges: the sign test accepts zero for either winding.
   assign covered = area_pos ? (e_ab >= 0 && e_bc >= 0 && e_ca >= 0)
                             : (e_ab <= 0 && e_bc <= 0 && e_ca <= 0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_valid <= 1'b0;
         done        <= 1'b0;
         pixel_addr  <= '0;
         pixel_color <= '0;
      end else begin
         pixel_valid <= (state == SCAN) && covered;
         done        <= finish;
         if (state == SCAN)   pixel_addr  <= addr;
         if (state == SETUP1) pixel_color <= tri_q.color;
      end
   end

endmodule

// File: tb/tb_tri_raster.sv
// Scoreboard bench for tri_raster: directed triangles push expected writes and
// done cycles; a negedge monitor pops and compares whatever the DUT presents.
module tb_tri_raster;

   localparam int H_RES = 320;
   localparam int V_RES = 240;
   localparam int ADDRW = 17;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [63:0]      tri_in;
   logic             ready_out;
   logic             pixel_valid;
   logic [ADDRW-1:0] pixel_addr;
   logic [9:0]       pixel_color;
   logic             done;

   tri_raster #(.H_RES(H_RES), .V_RES(V_RES), .ADDRW(ADDRW)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .tri_in(tri_in),
      .ready_out(ready_out), .pixel_valid(pixel_valid), .pixel_addr(pixel_addr),
      .pixel_color(pixel_color), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int color;
   } pix_t;

   pix_t pix_q[$];
   int   lat_q[$];
   int   done_q[$];
   pix_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pack(input int x1, input int y1, input int x2, input int y2,
                                        input int x3, input int y3, input int col);
      return {9'(x1), 9'(y1), 9'(x2), 9'(y2), 9'(x3), 9'(y3), 10'(col)};
   endfunction

   // Right triangle with legs of 4 at the screen centre: dx+dy <= 4.
   task automatic push_small(input int col);
      for (int dy = 0; dy <= 4; dy++)
         for (int dx = 0; dx <= 4 - dy; dx++)
            pix_q.push_back('{(120 + dy) * H_RES + 160 + dx, col});
   endtask

   // Screen-space triangle (-10,115),(10,115),(-10,135) clipped to x >= 0.
   task automatic push_clamped(input int col);
      for (int y = 115; y <= 135; y++)
         for (int x = 0; x <= 10; x++)
            if (x + y <= 125) pix_q.push_back('{y * H_RES + x, col});
   endtask

   task automatic send(input logic [63:0] t, input int lat);
      lat_q.push_back(lat);
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      tri_in   = t;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (ready_out) break;
      end
      check("send_accepted", 32'(ready_out), 32'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (ready_out && pix_q.size() == 0 && done_q.size() == 0 && lat_q.size() == 0) break;
      end
      repeat (2) @(negedge clk);
      check("drain_pixels", 32'(pix_q.size()), 32'd0);
      check("drain_done", 32'(done_q.size() + lat_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (valid_in && ready_out && lat_q.size() > 0)
            done_q.push_back(cyc + lat_q.pop_front());
         if (pixel_valid) begin
            check("write_expected", 32'(pix_q.size() > 0), 32'd1);
            if (pix_q.size() > 0) begin
               mon_e = pix_q.pop_front();
               check("pixel_addr", 32'(pixel_addr), 32'(mon_e.addr));
               check("pixel_color", 32'(pixel_color), 32'(mon_e.color));
            end
         end
         if (done) begin
            check("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            check("ready_with_done", 32'(ready_out), 32'd1);
         end
      end
   end

   initial begin
      int c0;
      rst      = 1'b1;
      valid_in = 1'b0;
      tri_in   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready_out), 32'd0);
      check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pixel_addr", 32'(pixel_addr), 32'd0);
      check("rst_pixel_color", 32'(pixel_color), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      push_small(10'h155);
      send(pack(0, 0, 4, 0, 0, 4, 10'h155), 28);
      wait_idle();

      push_small(10'h2AA);
      send(pack(0, 0, 0, 4, 4, 0, 10'h2AA), 28);
      wait_idle();

      send(pack(0, 0, 2, 2, 4, 4, 10'h3FF), 3);
      wait_idle();

      send(pack(-200, 0, -180, 0, -190, 10, 10'h001), 3);
      wait_idle();

      push_clamped(10'h0C3);
      send(pack(-170, -5, -150, -5, -170, 15, 10'h0C3), 234);
      wait_idle();

      // Back-to-back with valid_in held high across both triangles.
      push_small(10'h0F0);
      push_small(10'h30F);
      lat_q.push_back(28);
      lat_q.push_back(28);
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      tri_in   = pack(0, 0, 4, 0, 0, 4, 10'h0F0);
      @(negedge clk);
      c0 = cyc;
      check("b2b_first_ready", 32'(ready_out), 32'd1);
      @(posedge clk);
      #1;
      tri_in = pack(0, 0, 0, 4, 4, 0, 10'h30F);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready_out) break;
      end
      check("b2b_ready_cycle", 32'(cyc - c0), 32'd28);
      check("b2b_done_with_ready", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      wait_idle();

      // Reset while the first triangle is mid-scan.
      mon_en = 1'b0;
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      tri_in   = pack(0, 0, 4, 0, 0, 4, 10'h155);
      @(negedge clk);
      c0 = cyc;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("pre_reset_write", 32'(pixel_valid), 32'd1);
      check("pre_reset_cycle", 32'(cyc - c0), 32'd10);
      @(negedge clk);
      check("mid_rst_pixel_valid", 32'(pixel_valid), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_ready", 32'(ready_out), 32'd0);
      check("mid_rst_pixel_addr", 32'(pixel_addr), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_idle", 32'(ready_out), 32'd1);

      push_small(10'h155);
      send(pack(0, 0, 4, 0, 0, 4, 10'h155), 28);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
